alu_iterative_exec: RTL and testbench

//  Execution-side consumer of the 4-bit ALU Operation code produced by the ALU control decoder.

---
 rtl/alu_iterative_exec_if.sv | 26 ++
 rtl/alu_iterative_exec.sv | 131 +++++++++++++
 tb/tb_alu_iterative_exec.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_iterative_exec_if.sv
// Request/result channel between operand select and the iterative ALU.
// Master is the requester and result consumer; slave is the ALU.
interface alu_iterative_exec_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            Operation;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic                  Zero;
  logic                  Illegal;

  modport master (
    output in_valid, Operation, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, Zero, Illegal
  );

  modport slave (
    input  in_valid, Operation, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, Zero, Illegal
  );
endinterface

// File: rtl/alu_iterative_exec.sv
// Iterative ALU: single-cycle logic/arith/compare, shifts one bit per cycle.
// Result, Zero and Illegal are registered and held until the consumer takes them.
module alu_iterative_exec #(
  parameter int DATA_WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  alu_iterative_exec_if.slave bus
);
  localparam int SW = $clog2(DATA_WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_NE   = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_PASB = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_EQ   = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_LT   = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1110;
  localparam logic [3:0] OP_GE   = 4'b1111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, sh_next;
  logic [SW-1:0]         cnt_q;
  logic [3:0]            op_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  zero_q, illegal_q;

  logic                  accept, is_shift, alu_ill;
  logic [SW-1:0]         shamt;
  logic [DATA_WIDTH-1:0] alu_res;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.ALUResult = result_q;
  assign bus.Zero      = zero_q;
  assign bus.Illegal   = illegal_q;

  assign accept   = bus.in_valid && (state_q == IDLE);
  assign shamt    = bus.SrcB[SW-1:0];
  assign is_shift = (bus.Operation == OP_SLL) || (bus.Operation == OP_SRL) ||
                    (bus.Operation == OP_SRA);

  // Single-cycle result; shift codes land here only with a zero shift amount.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    alu_res = '0;
    alu_ill = 1'b0;
    case (bus.Operation)
      OP_AND:  alu_res = bus.SrcA & bus.SrcB;
      OP_OR:   alu_res = bus.SrcA | bus.SrcB;
      OP_ADD:  alu_res = bus.SrcA + bus.SrcB;
      OP_SUB:  alu_res = bus.SrcA - bus.SrcB;
      OP_XOR:  alu_res = bus.SrcA ^ bus.SrcB;
      OP_PASB: alu_res = bus.SrcB;
      OP_SLL, OP_SRL, OP_SRA: alu_res = bus.SrcA;
      OP_SLT, OP_LT:
        alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(bus.SrcA) < $signed(bus.SrcB)};
      OP_GE:
        alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(bus.SrcA) >= $signed(bus.SrcB)};
      OP_EQ:   alu_res = {{(DATA_WIDTH-1){1'b0}}, bus.SrcA == bus.SrcB};
      OP_NE:   alu_res = {{(DATA_WIDTH-1){1'b0}}, bus.SrcA != bus.SrcB};
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    sh_next = {shreg_q[DATA_WIDTH-1], shreg_q[DATA_WIDTH-1:1]};
    if (op_q == OP_SLL)      sh_next = {shreg_q[DATA_WIDTH-2:0], 1'b0};
    else if (op_q == OP_SRL) sh_next = {1'b0, shreg_q[DATA_WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (is_shift && shamt != '0) ? SHIFT : DONE;
      SHIFT:   if (cnt_q == SW'(1)) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: datapath registers are reset too, because the outputs and counter must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          if (is_shift && shamt != '0) begin
            shreg_q <= bus.SrcA;
            cnt_q   <= shamt;
            op_q    <= bus.Operation;
          end else begin
            result_q  <= alu_res;
            zero_q    <= (alu_res == '0);
            illegal_q <= alu_ill;
          end
        end
        SHIFT: begin
          shreg_q <= sh_next;
          cnt_q   <= cnt_q - SW'(1);
          if (cnt_q == SW'(1)) begin
            result_q  <= sh_next;
            zero_q    <= (sh_next == '0);
            illegal_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_iterative_exec.sv
// Directed bench for alu_iterative_exec: latency, shifts, backpressure,
// reset in mid-shift, illegal codes and zero-length shifts.
module tb_alu_iterative_exec;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;

  alu_iterative_exec_if #(.DATA_WIDTH(W)) bus ();
  alu_iterative_exec #(.DATA_WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle, then scramble the inputs to prove they are not re-sampled.
  task automatic issue(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    bus.Operation = op;
    bus.SrcA      = a;
    bus.SrcB      = b;
    bus.in_valid  = 1'b1;
    check({tag, " in_ready before accept"}, {31'd0, bus.in_ready}, 32'd1);
    cyc();
    bus.in_valid  = 1'b0;
    bus.Operation = 4'b1011;
    bus.SrcA      = 32'hDEAD_BEEF;
    bus.SrcB      = 32'hFFFF_FFFF;
  endtask

  task automatic check_done(input string tag, input logic [W-1:0] res, input logic zero,
                            input logic ill);
    check({tag, " out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, " ALUResult"}, bus.ALUResult, res);
    check({tag, " Zero"}, {31'd0, bus.Zero}, {31'd0, zero});
    check({tag, " Illegal"}, {31'd0, bus.Illegal}, {31'd0, ill});
  endtask

  task automatic take(input string tag);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    check({tag, " out_valid after take"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, " in_ready after take"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic shift_wait(input string tag, input int k);
    for (int i = 0; i < k; i++) begin
      check({tag, " in_ready low in SHIFT"}, {31'd0, bus.in_ready}, 32'd0);
      check({tag, " out_valid low in SHIFT"}, {31'd0, bus.out_valid}, 32'd0);
      cyc();
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.Operation = 4'b0000;
    bus.SrcA      = '0;
    bus.SrcB      = '0;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset ALUResult", bus.ALUResult, 32'd0);
    check("reset Zero", {31'd0, bus.Zero}, 32'd0);
    check("reset Illegal", {31'd0, bus.Illegal}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    cyc();
    check("post-reset in_ready", {31'd0, bus.in_ready}, 32'd1);

    issue("ADD", 4'b0010, 32'd5, 32'd7);
    check_done("ADD", 32'd12, 1'b0, 1'b0);
    take("ADD");

    issue("SUB", 4'b0011, 32'd7, 32'd7);
    check_done("SUB", 32'd0, 1'b1, 1'b0);
    take("SUB");

    issue("LT", 4'b1100, 32'hFFFF_FFFF, 32'd1);
    check_done("LT", 32'd1, 1'b0, 1'b0);
    take("LT");

    issue("GE", 4'b1111, 32'hFFFF_FFFF, 32'd1);
    check_done("GE", 32'd0, 1'b1, 1'b0);
    take("GE");

    issue("XOR", 4'b1110, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check_done("XOR", 32'h0FF0_0FF0, 1'b0, 1'b0);
    take("XOR");

    issue("SLT", 4'b0101, 32'h7FFF_FFFF, 32'h8000_0000);
    check_done("SLT", 32'd0, 1'b1, 1'b0);
    take("SLT");

    issue("EQ", 4'b1000, 32'h55, 32'h55);
    check_done("EQ", 32'd1, 1'b0, 1'b0);
    take("EQ");

    issue("PASSB", 4'b0110, 32'h1111, 32'hCAFE);
    check_done("PASSB", 32'hCAFE, 1'b0, 1'b0);
    take("PASSB");

    issue("SRA", 4'b1010, 32'h8000_0000, 32'd4);
    shift_wait("SRA", 4);
    check_done("SRA", 32'hF800_0000, 1'b0, 1'b0);
    take("SRA");

    issue("SRL", 4'b0111, 32'h8000_0000, 32'd4);
    shift_wait("SRL", 4);
    check_done("SRL", 32'h0800_0000, 1'b0, 1'b0);
    take("SRL");

    // Backpressure: result held, a new request waits until the slot frees.
    issue("BP AND", 4'b0000, 32'hFF00_FF00, 32'h0F0F_0F0F);
    bus.Operation = 4'b0001;
    bus.SrcA      = 32'h0000_00F0;
    bus.SrcB      = 32'h0000_0F00;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_done("BP held", 32'h0F00_0F00, 1'b0, 1'b0);
      check("BP in_ready low", {31'd0, bus.in_ready}, 32'd0);
      cyc();
    end
    check_done("BP still held", 32'h0F00_0F00, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    check("BP no bypass out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("BP in_ready after take", {31'd0, bus.in_ready}, 32'd1);
    cyc();
    bus.in_valid = 1'b0;
    check_done("BP OR", 32'h0000_0FF0, 1'b0, 1'b0);
    take("BP OR");

    issue("ILLEGAL", 4'b1011, 32'h1234, 32'h5678);
    check_done("ILLEGAL", 32'd0, 1'b1, 1'b1);
    take("ILLEGAL");

    // Reset in the middle of a long shift discards it.
    issue("SLL20", 4'b1001, 32'd1, 32'd20);
    shift_wait("SLL20", 5);
    rst_n = 1'b0;
    #1;
    check("mid-shift reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid-shift reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mid-shift reset ALUResult", bus.ALUResult, 32'd0);
    check("mid-shift reset Zero", {31'd0, bus.Zero}, 32'd0);
    check("mid-shift reset Illegal", {31'd0, bus.Illegal}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    cyc();
    repeat (20) cyc();
    check("after reset no stale result", {31'd0, bus.out_valid}, 32'd0);

    issue("ADD wrap", 4'b0010, 32'hFFFF_FFFF, 32'd2);
    check_done("ADD wrap", 32'd1, 1'b0, 1'b0);
    take("ADD wrap");

    issue("SLL by 0", 4'b1001, 32'h1234_5678, 32'h0000_0020);
    check_done("SLL by 0", 32'h1234_5678, 1'b0, 1'b0);
    take("SLL by 0");

    issue("SLL by 31", 4'b1001, 32'h0000_0003, 32'd31);
    shift_wait("SLL by 31", 31);
    check_done("SLL by 31", 32'h8000_0000, 1'b0, 1'b0);
    take("SLL by 31");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
